// File: rtl/coffee_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : coffee_sequencer_if
//  Description : Request/status bundle between a brew controller front panel
//                and the coffee_sequencer core.
//  Revision    : 1.0  initial release
// ============================================================================
interface coffee_sequencer_if;
    logic       start;
    logic [1:0] drink;
    logic       cancel;
    logic [3:0] selection;
    logic       busy;
    logic       done;
    logic       error;

    // Requester side: issues brew/cancel requests, observes status.
    modport master (
        output start,
        output drink,
        output cancel,
        input  selection,
        input  busy,
        input  done,
        input  error
    );

    // Sequencer side: consumes requests, reports status.
    modport slave (
        input  start,
        input  drink,
        input  cancel,
        output selection,
        output busy,
        output done,
        output error
    );
endinterface
`default_nettype wire

// File: rtl/coffee_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : coffee_sequencer
//  Description : Recipe sequencer for a coffee machine. Steps through
//                HEAT/GRIND/POUR/[MILK]/DONE phases of a latched recipe,
//                supports cancel to ABORT, and flags invalid requests.
//                The state code doubles as the display multiplexer select.
//  Revision    : 1.0  initial release
// ============================================================================
module coffee_sequencer #(
    parameter int PHASE_TICKS = 10,
    parameter int TICK_WIDTH  = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    coffee_sequencer_if.slave  bus
);

    // State encoding equals the selection code shown on the display.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        HEAT  = 4'd1,
        GRIND = 4'd2,
        POUR  = 4'd3,
        MILK  = 4'd4,
        DONE  = 4'd5,
        ABORT = 4'd14
    } state_t;

    localparam logic [1:0]            c_drink_espresso   = 2'b00;
    localparam logic [1:0]            c_drink_cappuccino = 2'b10;
    localparam logic [1:0]            c_drink_invalid    = 2'b11;
    localparam logic [3:0]            c_sel_error        = 4'hF;
    localparam logic [TICK_WIDTH-1:0] c_last_single      = TICK_WIDTH'(PHASE_TICKS - 1);
    localparam logic [TICK_WIDTH-1:0] c_last_double      = TICK_WIDTH'(2 * PHASE_TICKS - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [TICK_WIDTH-1:0]   r_tick;
    logic [TICK_WIDTH-1:0]   w_tick_next;
    logic [1:0]              r_drink;
    logic [1:0]              w_drink_next;
    logic                    r_error;
    logic                    w_error_next;
    logic [TICK_WIDTH-1:0]   w_phase_last;
    logic                    w_phase_end;
    logic                    w_request;

    // Only cappuccino stretches the MILK phase to two phase lengths.
    assign w_phase_last = ((r_state == MILK) && (r_drink == c_drink_cappuccino))
                          ? c_last_double : c_last_single;
    assign w_phase_end  = (r_tick == w_phase_last);
    assign w_request    = bus.start && !bus.cancel;

    // State, tick counter, latched recipe and error pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_drink <= c_drink_espresso;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_tick  <= w_tick_next;
            r_drink <= w_drink_next;
            r_error <= w_error_next;
        end
    end

    // Next-state, recipe latch and counter control.
    always_comb begin
        w_state_next = r_state;
        w_drink_next = r_drink;
        w_error_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_request) begin
                    if (bus.drink == c_drink_invalid) begin
                        w_error_next = 1'b1;
                    end else begin
                        w_state_next = HEAT;
                        w_drink_next = bus.drink;
                    end
                end
            end
            HEAT: begin
                if (bus.cancel)       w_state_next = ABORT;
                else if (w_phase_end) w_state_next = GRIND;
            end
            GRIND: begin
                if (bus.cancel)       w_state_next = ABORT;
                else if (w_phase_end) w_state_next = POUR;
            end
            POUR: begin
                if (bus.cancel)       w_state_next = ABORT;
                else if (w_phase_end) w_state_next = (r_drink == c_drink_espresso) ? DONE : MILK;
            end
            MILK: begin
                if (bus.cancel)       w_state_next = ABORT;
                else if (w_phase_end) w_state_next = DONE;
            end
            DONE: begin
                // Cancel has no effect once the drink is complete.
                if (w_phase_end)      w_state_next = IDLE;
            end
            ABORT: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Counter restarts on every state entry and idles at zero,
        // so it can never run past the longest phase.
        if ((w_state_next != r_state) || (r_state == IDLE) || (r_state == ABORT)) begin
            w_tick_next = '0;
        end else begin
            w_tick_next = r_tick + 1'b1;
        end
    end

    assign bus.selection = r_error ? c_sel_error : r_state;
    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE) && (r_tick == '0);
    assign bus.error     = r_error;

endmodule
`default_nettype wire

// File: tb/tb_coffee_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_coffee_sequencer
//  Description : Directed self-checking bench for coffee_sequencer with
//                PHASE_TICKS=4.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_coffee_sequencer;

    localparam int c_n = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    coffee_sequencer_if bus();

    coffee_sequencer #(
        .PHASE_TICKS (c_n),
        .TICK_WIDTH  (8)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_sel"},   int'(bus.selection), 0);
        check({tag, "_busy"},  int'(bus.busy),      0);
        check({tag, "_done"},  int'(bus.done),      0);
        check({tag, "_error"}, int'(bus.error),     0);
    endtask

    // Check that the current phase shows 'sel' for 'len' cycles; done only on first DONE cycle.
    task automatic expect_phase(input string tag, input int sel, input int len);
        for (int i = 0; i < len; i++) begin
            check({tag, "_sel"},   int'(bus.selection), sel);
            check({tag, "_busy"},  int'(bus.busy),      1);
            check({tag, "_done"},  int'(bus.done),      (sel == 5 && i == 0) ? 1 : 0);
            check({tag, "_error"}, int'(bus.error),     0);
            step();
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.drink  = 2'b00;
        bus.cancel = 1'b0;
        #2;
        expect_idle("reset");
        step();
        rst = 1'b0;
        step();
        expect_idle("post_reset");

        // Espresso: 1,2,3,5 each 4 cycles, busy 16 cycles.
        bus.start = 1'b1; bus.drink = 2'b00;
        step();
        bus.start = 1'b0;
        expect_phase("esp_heat",  1, c_n);
        expect_phase("esp_grind", 2, c_n);
        expect_phase("esp_pour",  3, c_n);
        expect_phase("esp_done",  5, c_n);
        expect_idle("esp_end");

        // Cappuccino with drink changed mid-brew: MILK lasts 8 cycles.
        bus.start = 1'b1; bus.drink = 2'b10;
        step();
        bus.start = 1'b0; bus.drink = 2'b00;
        expect_phase("cap_heat",  1, c_n);
        expect_phase("cap_grind", 2, c_n);
        expect_phase("cap_pour",  3, c_n);
        expect_phase("cap_milk",  4, 2 * c_n);
        expect_phase("cap_done",  5, c_n);
        expect_idle("cap_end");

        // Invalid drink: one error cycle with selection 15, never busy.
        bus.start = 1'b1; bus.drink = 2'b11;
        step();
        bus.start = 1'b0;
        check("inv_sel",   int'(bus.selection), 15);
        check("inv_error", int'(bus.error),     1);
        check("inv_busy",  int'(bus.busy),      0);
        step();
        expect_idle("inv_end");

        // Latte cancelled in the second POUR cycle.
        bus.start = 1'b1; bus.drink = 2'b01;
        step();
        bus.start = 1'b0;
        expect_phase("lat_heat",  1, c_n);
        expect_phase("lat_grind", 2, c_n);
        expect_phase("lat_pour1", 3, 1);
        bus.cancel = 1'b1;
        expect_phase("lat_pour2", 3, 1);
        bus.cancel = 1'b0;
        check("abort_sel",  int'(bus.selection), 14);
        check("abort_busy", int'(bus.busy),      1);
        check("abort_done", int'(bus.done),      0);
        step();
        expect_idle("abort_end");
        step();
        expect_idle("abort_end2");

        // Asynchronous reset mid-GRIND, then start on the first edge after release.
        bus.start = 1'b1; bus.drink = 2'b01;
        step();
        bus.start = 1'b0;
        expect_phase("rst_heat",  1, c_n);
        expect_phase("rst_grind", 2, 1);
        rst = 1'b1;
        #1;
        expect_idle("async_reset");
        step();
        rst = 1'b0;
        bus.start = 1'b1; bus.drink = 2'b00;
        step();
        bus.start = 1'b0;
        expect_phase("rel_heat",  1, c_n);
        expect_phase("rel_grind", 2, c_n);
        expect_phase("rel_pour",  3, c_n);
        expect_phase("rel_done",  5, c_n);
        expect_idle("rel_end");

        // start with cancel in IDLE is ignored.
        bus.start = 1'b1; bus.cancel = 1'b1; bus.drink = 2'b00;
        step();
        bus.start = 1'b0; bus.cancel = 1'b0;
        expect_idle("start_cancel");

        // Espresso with start held through HEAT: no effect, no requeue.
        bus.start = 1'b1; bus.drink = 2'b00;
        step();
        expect_phase("rep_heat",  1, c_n);
        bus.start = 1'b0;
        expect_phase("rep_grind", 2, c_n);
        expect_phase("rep_pour",  3, c_n);
        expect_phase("rep_done",  5, c_n);
        expect_idle("rep_end");
        step();
        expect_idle("rep_end2");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
